// File: rtl/dcache_dm.sv
// Direct-mapped, write-back, write-allocate data cache with 32-byte lines.
// Hits are answered combinationally from flop arrays; misses move whole lines over the pmem port.
module dcache_dm #(
    parameter int S_INDEX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic         mem_resp,
    output logic [31:0]  mem_rdata,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int SETS  = 1 << S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t state, state_next;

    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  dirty_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [255:0]     line_q [SETS];
    logic [26:0]      miss_line_q;

    logic [S_INDEX-1:0] req_idx;
    logic [S_INDEX-1:0] miss_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [TAG_W-1:0]   miss_tag;
    logic [2:0]         word_sel;
    logic [31:0]        hit_word;
    logic [31:0]        merged_word;
    logic [1:0]         unused_addr_bits;
    logic               req;
    logic               hit;
    logic               wr_hit;
    logic               miss_start;
    logic               wb_done;
    logic               fill_done;

    assign req_idx          = mem_address[4+S_INDEX:5];
    assign req_tag          = mem_address[31:5+S_INDEX];
    assign word_sel         = mem_address[4:2];
    assign unused_addr_bits = mem_address[1:0];

    // The miss line is latched so pmem_address stays put even if the request wanders.
    assign miss_idx = miss_line_q[S_INDEX-1:0];
    assign miss_tag = miss_line_q[26:S_INDEX];

    assign req       = mem_read | mem_write;
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign hit_word  = line_q[req_idx][{word_sel, 5'b00000} +: 32];
    assign mem_rdata = hit_word;

    always_comb begin
        merged_word = hit_word;
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) merged_word[8*b +: 8] = mem_wdata[8*b +: 8];
        end
    end

    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        wr_hit       = 1'b0;
        miss_start   = 1'b0;
        wb_done      = 1'b0;
        fill_done    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        wr_hit   = mem_write;
                    end else begin
                        miss_start = 1'b1;
                        state_next = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[miss_idx], miss_idx, 5'b00000};
                pmem_wdata   = line_q[miss_idx];
                if (pmem_resp) begin
                    wb_done    = 1'b1;
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {miss_line_q, 5'b00000};
                if (pmem_resp) begin
                    fill_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state <= state_next;
            if (wr_hit)  dirty_q[req_idx]  <= 1'b1;
            if (wb_done) dirty_q[miss_idx] <= 1'b0;
            if (fill_done) begin
                valid_q[miss_idx] <= 1'b1;
                dirty_q[miss_idx] <= 1'b0;
            end
        end
    end

    // Line, tag and miss-address storage carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (miss_start) miss_line_q <= mem_address[31:5];
        if (fill_done) begin
            line_q[miss_idx] <= pmem_rdata;
            tag_q[miss_idx]  <= miss_tag;
        end
        if (wr_hit) line_q[req_idx][{word_sel, 5'b00000} +: 32] <= merged_word;
    end

endmodule

// File: tb/tb_dcache_dm.sv
// Bench for dcache_dm: directed scenarios plus randomized traffic against a
// flat-memory reference model with a per-set residency table.
module tb_dcache_dm;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address, mem_wdata;
    logic         mem_resp;
    logic [31:0]  mem_rdata;
    logic [31:0]  pmem_address;
    logic         pmem_read, pmem_write;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    dcache_dm #(.S_INDEX(3)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int mem_lat  = 1;
    int excl_viol = 0;
    int addr_viol = 0;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } xfer_t;
    xfer_t xlog[$];

    logic [255:0] pmem_store [int unsigned];
    logic [31:0]  arch [int unsigned];
    bit           rv [8];
    bit           rdty [8];
    logic [23:0]  rt [8];

    function automatic logic [31:0] default_word(input int unsigned wa);
        return 32'h1000_0000 + wa - 32'd16;
    endfunction

    function automatic logic [255:0] mem_line(input int unsigned ln);
        logic [255:0] l;
        if (pmem_store.exists(ln)) return pmem_store[ln];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = default_word(ln*8 + w);
        return l;
    endfunction

    function automatic logic [31:0] arch_get(input int unsigned wa);
        logic [255:0] l;
        if (arch.exists(wa)) return arch[wa];
        if (pmem_store.exists(wa >> 3)) begin
            l = pmem_store[wa >> 3];
            return l[(wa & 7)*32 +: 32];
        end
        return default_word(wa);
    endfunction

    task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] be);
        logic [2:0]  s;
        logic [31:0] w;
        s = a[7:5];
        if (!(rv[s] && rt[s] == a[31:8])) begin
            rv[s] = 1'b1; rt[s] = a[31:8]; rdty[s] = 1'b0;
        end
        if (wr) begin
            w = arch_get(a >> 2);
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            arch[a >> 2] = w;
            rdty[s] = 1'b1;
        end
    endtask

    // Reset throws away dirty lines: those words fall back to what memory holds.
    task automatic model_reset();
        int unsigned ln;
        for (int s = 0; s < 8; s++) begin
            if (rv[s] && rdty[s]) begin
                ln = {8'h00, rt[s]} * 8 + s;
                for (int w = 0; w < 8; w++) arch.delete(ln*8 + w);
            end
            rv[s] = 1'b0; rdty[s] = 1'b0;
        end
    endtask

    // Physical memory responder: pmem_resp on the mem_lat-th cycle of a request.
    initial begin
        int          cnt;
        logic [31:0] held;
        cnt = 0; held = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (rst) cnt = 0;
            else if (pmem_read || pmem_write) begin
                if (pmem_read && pmem_write) excl_viol++;
                if (cnt > 0 && pmem_address !== held) addr_viol++;
                held = pmem_address;
                cnt++;
                if (cnt >= mem_lat) begin
                    pmem_resp = 1'b1;
                    cnt = 0;
                    if (pmem_write) begin
                        pmem_store[pmem_address >> 5] = pmem_wdata;
                        xlog.push_back('{1'b1, pmem_address, pmem_wdata});
                    end else begin
                        pmem_rdata = mem_line(pmem_address >> 5);
                        xlog.push_back('{1'b0, pmem_address, pmem_rdata});
                    end
                end
            end else cnt = 0;
        end
    end

    // Called just after a rising edge; returns just after the edge that completes the request.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, output int lat, output logic [31:0] rdata);
        mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = wd; mem_byte_enable = be;
        lat = -1; rdata = 'x;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_resp === 1'b1) begin
                lat = i; rdata = mem_rdata;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic go_idle();
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_read = 0; mem_write = 0; mem_byte_enable = 0; mem_address = 0; mem_wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (mem_resp !== 1'b0) $display("FAIL reset_mem_resp got %b want 0", mem_resp); else n_pass++;
        n_checks++; if (pmem_read !== 1'b0) $display("FAIL reset_pmem_read got %b want 0", pmem_read); else n_pass++;
        n_checks++; if (pmem_write !== 1'b0) $display("FAIL reset_pmem_write got %b want 0", pmem_write); else n_pass++;
        n_checks++; if (pmem_address !== 32'h0) $display("FAIL reset_pmem_address got %h want 0", pmem_address); else n_pass++;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        int lat; logic [31:0] rd;
        mem_lat = 3; xlog.delete();
        access(1, 0, 32'h40, 0, 0, lat, rd); model_access(0, 32'h40, 0, 0);
        n_checks++; if (lat != 4) $display("FAIL fill_latency got %0d want 4", lat); else n_pass++;
        n_checks++; if (rd !== 32'h1000_0000) $display("FAIL fill_rdata got %h want 10000000", rd); else n_pass++;
        n_checks++;
        if (xlog.size() != 1 || xlog[0].wr || xlog[0].addr !== 32'h40)
            $display("FAIL fill_pmem got %0d transfers want 1 read of 00000040", xlog.size());
        else n_pass++;
    endtask

    task automatic test_hit();
        int lat; logic [31:0] rd;
        xlog.delete();
        access(1, 0, 32'h44, 0, 0, lat, rd); model_access(0, 32'h44, 0, 0);
        n_checks++; if (lat != 0) $display("FAIL hit_latency got %0d want 0", lat); else n_pass++;
        n_checks++; if (rd !== 32'h1000_0001) $display("FAIL hit_rdata got %h want 10000001", rd); else n_pass++;
        n_checks++; if (xlog.size() != 0) $display("FAIL hit_pmem got %0d transfers want 0", xlog.size()); else n_pass++;
    endtask

    task automatic test_write_merge();
        int lat; logic [31:0] rd;
        access(0, 1, 32'h48, 32'hAABB_CCDD, 4'b0101, lat, rd); model_access(1, 32'h48, 32'hAABB_CCDD, 4'b0101);
        n_checks++; if (lat != 0) $display("FAIL write_hit_latency got %0d want 0", lat); else n_pass++;
        access(1, 0, 32'h48, 0, 0, lat, rd); model_access(0, 32'h48, 0, 0);
        n_checks++; if (rd !== 32'h10BB_00DD) $display("FAIL write_merge got %h want 10bb00dd", rd); else n_pass++;
    endtask

    task automatic test_evict();
        int lat; logic [31:0] rd;
        mem_lat = 2; xlog.delete();
        access(1, 0, 32'h140, 0, 0, lat, rd); model_access(0, 32'h140, 0, 0);
        n_checks++; if (lat != 5) $display("FAIL evict_latency got %0d want 5", lat); else n_pass++;
        n_checks++;
        if (xlog.size() != 2) $display("FAIL evict_count got %0d want 2", xlog.size());
        else if (!xlog[0].wr || xlog[0].addr !== 32'h40 || xlog[0].data[95:64] !== 32'h10BB_00DD)
            $display("FAIL evict_writeback got wr=%b addr=%h word2=%h want wr=1 addr=00000040 word2=10bb00dd",
                     xlog[0].wr, xlog[0].addr, xlog[0].data[95:64]);
        else if (xlog[1].wr || xlog[1].addr !== 32'h140)
            $display("FAIL evict_fill got wr=%b addr=%h want read of 00000140", xlog[1].wr, xlog[1].addr);
        else n_pass++;
        n_checks++; if (rd !== 32'h1000_0040) $display("FAIL evict_rdata got %h want 10000040", rd); else n_pass++;
    endtask

    task automatic test_rw_both();
        int lat; logic [31:0] rd;
        xlog.delete();
        access(1, 1, 32'h44, 32'hFFFF_FFFF, 4'hF, lat, rd); model_access(1, 32'h44, 32'hFFFF_FFFF, 4'hF);
        n_checks++; if (lat != 3) $display("FAIL rw_latency got %0d want 3", lat); else n_pass++;
        access(1, 0, 32'h44, 0, 0, lat, rd); model_access(0, 32'h44, 0, 0);
        n_checks++; if (rd !== 32'hFFFF_FFFF) $display("FAIL rw_as_write got %h want ffffffff", rd); else n_pass++;
        access(1, 0, 32'h48, 0, 0, lat, rd); model_access(0, 32'h48, 0, 0);
        n_checks++; if (rd !== 32'h10BB_00DD) $display("FAIL refill_after_wb got %h want 10bb00dd", rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat0, lat1; logic [31:0] rd0, rd1;
        access(1, 0, 32'h40, 0, 0, lat0, rd0); model_access(0, 32'h40, 0, 0);
        access(1, 0, 32'h4C, 0, 0, lat1, rd1); model_access(0, 32'h4C, 0, 0);
        n_checks++; if (lat0 != 0 || lat1 != 0) $display("FAIL b2b_latency got %0d,%0d want 0,0", lat0, lat1); else n_pass++;
        n_checks++; if (rd1 !== 32'h1000_0003) $display("FAIL b2b_rdata got %h want 10000003", rd1); else n_pass++;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_resp !== 1'b0) $display("FAIL idle_resp got %b want 0", mem_resp); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_miss();
        int lat; logic [31:0] rd;
        mem_lat = 6;
        mem_read = 1'b1; mem_write = 1'b0; mem_address = 32'hA0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (pmem_read !== 1'b1 || pmem_address !== 32'hA0)
            $display("FAIL alloc_req got read=%b addr=%h want 1 000000a0", pmem_read, pmem_address); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1; mem_read = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0)
            $display("FAIL abort_pmem got read=%b write=%b want 0 0", pmem_read, pmem_write); else n_pass++;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        mem_lat = 2; xlog.delete();
        access(1, 0, 32'h40, 0, 0, lat, rd); model_access(0, 32'h40, 0, 0);
        n_checks++; if (lat != 3 || xlog.size() != 1)
            $display("FAIL post_reset_miss got lat=%0d xfers=%0d want 3 1", lat, xlog.size()); else n_pass++;
        access(1, 0, 32'h44, 0, 0, lat, rd); model_access(0, 32'h44, 0, 0);
        n_checks++; if (rd !== 32'h1000_0001) $display("FAIL dirty_lost got %h want 10000001", rd); else n_pass++;
        go_idle();
    endtask

    task automatic test_random();
        logic [23:0]  tags [4];
        logic [31:0]  a, wd, exp_rd, rd, victim;
        logic [255:0] vline;
        logic [3:0]   be;
        logic [2:0]   s;
        bit           rd_op, wr_op, hit, wb;
        int           op, lat, exp_lat, exp_n;
        tags[0] = 24'h0; tags[1] = 24'h1; tags[2] = 24'h0ABCDE; tags[3] = 24'hFFFFFF;
        for (int it = 0; it < 200; it++) begin
            a  = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00};
            wd = $urandom; be = 4'($urandom_range(0, 15));
            op = $urandom_range(0, 3);
            rd_op = (op != 2); wr_op = (op >= 2);
            mem_lat = $urandom_range(1, 3);
            s   = a[7:5];
            hit = rv[s] && rt[s] == a[31:8];
            wb  = !hit && rv[s] && rdty[s];
            exp_lat = hit ? 0 : (wb ? mem_lat : 0) + mem_lat + 1;
            exp_n   = hit ? 0 : (wb ? 2 : 1);
            victim  = {rt[s], s, 5'b00000};
            for (int w = 0; w < 8; w++) vline[w*32 +: 32] = arch_get((victim >> 2) + w);
            exp_rd = arch_get(a >> 2);
            xlog.delete();
            access(rd_op, wr_op, a, wd, be, lat, rd);
            model_access(wr_op, a, wd, be);
            n_checks++; if (lat != exp_lat)
                $display("FAIL rand_latency addr=%h got %0d want %0d", a, lat, exp_lat); else n_pass++;
            n_checks++;
            if (xlog.size() != exp_n)
                $display("FAIL rand_xfers addr=%h got %0d want %0d", a, xlog.size(), exp_n);
            else if (wb && (!xlog[0].wr || xlog[0].addr !== victim || xlog[0].data !== vline))
                $display("FAIL rand_writeback got addr=%h want %h", xlog[0].addr, victim);
            else if (exp_n > 0 && (xlog[exp_n-1].wr || xlog[exp_n-1].addr !== {a[31:5], 5'b00000}))
                $display("FAIL rand_fill got addr=%h want %h", xlog[exp_n-1].addr, {a[31:5], 5'b00000});
            else n_pass++;
            if (rd_op && !wr_op) begin
                n_checks++; if (rd !== exp_rd)
                    $display("FAIL rand_rdata addr=%h got %h want %h", a, rd, exp_rd); else n_pass++;
            end
        end
        go_idle();
    endtask

    task automatic test_protocol();
        n_checks++; if (excl_viol != 0) $display("FAIL pmem_exclusive got %0d overlaps want 0", excl_viol); else n_pass++;
        n_checks++; if (addr_viol != 0) $display("FAIL pmem_addr_stable got %0d changes want 0", addr_viol); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hit();
        test_write_merge();
        test_evict();
        test_rw_both();
        test_back_to_back();
        test_reset_mid_miss();
        test_random();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
